// File: rtl/flag_pkg.sv
// flag_pkg: flag bit positions, flag width and ALU opcode encodings shared by the flag status unit.
package flag_pkg;
  localparam int FLAG_W = 6;
  localparam int F_Z  = 0;
  localparam int F_C  = 1;
  localparam int F_N  = 2;
  localparam int F_V  = 3;
  localparam int F_DD = 4;
  localparam int F_DZ = 5;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
endpackage

// File: rtl/flag_stack.sv
// flag_stack: LIFO of saved flag words with full/empty status and a sticky misuse error.
module flag_stack #(
  parameter int FLAG_W      = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [FLAG_W-1:0] din,
  output logic [FLAG_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              err
);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  logic [FLAG_W-1:0] mem [STACK_DEPTH];
  logic [DW-1:0]     depth;
  logic              do_push, do_pop;
  assign full    = depth == DW'(STACK_DEPTH);
  assign empty   = depth == '0;
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign dout    = mem[AW'(depth - DW'(1))];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      depth <= '0;
      err   <= 1'b0;
    end else begin
      if (do_push) depth <= depth + DW'(1);
      else if (do_pop) depth <= depth - DW'(1);
      err <= (err & ~clr) | (push & ~pop & full) | (pop & ~push & empty);
    end
  // storage is deliberately not reset; depth alone defines valid contents
  always_ff @(posedge clk)
    if (do_push) mem[AW'(depth)] <= din;
endmodule

// File: rtl/flag_status_unit.sv
// flag_status_unit: registered ALU status flags {DZ,DD,V,N,C,Z} with optional save/restore stack.
// Define FLAG_STACK_EN to build the flag save stack; otherwise push/pop are ignored.
module flag_status_unit
  import flag_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [DATA_W-1:0] result,
  input  logic              carry_out,
  input  logic              overflow_out,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] src2,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  output logic [FLAG_W-1:0] flags,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);
  logic [FLAG_W-1:0] alu_f, base_f, next_f, stack_top;
  logic              pop_ok, is_div, div0, ld_cv, clr_cv;
`ifdef FLAG_STACK_EN
  flag_stack #(.FLAG_W(FLAG_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr(clr_err),
    .din(flags), .dout(stack_top), .full(stack_full), .empty(stack_empty), .err(stack_err)
  );
  assign pop_ok = pop & ~push & ~stack_empty;
`else
  localparam int unused_depth = STACK_DEPTH;
  logic unused_stack;
  assign unused_stack = ^{push, pop};
  assign stack_top    = '0;
  assign stack_full   = 1'b0;
  assign stack_empty  = 1'b1;
  assign stack_err    = 1'b0;
  assign pop_ok       = 1'b0;
`endif
  assign is_div = opcode == OP_DIV;
  assign div0   = alu_valid & is_div & (src2 == '0);
  assign ld_cv  = (opcode == OP_ADD) | (opcode == OP_SUB);
  assign clr_cv = (opcode == OP_MUL) | is_div;
  always_comb begin
    alu_f        = flags;
    alu_f[F_Z]   = result == '0;
    alu_f[F_N]   = result[DATA_W-1];
    alu_f[F_C]   = ld_cv ? carry_out : clr_cv ? 1'b0 : flags[F_C];
    alu_f[F_V]   = ld_cv ? overflow_out : clr_cv ? 1'b0 : flags[F_V];
    alu_f[F_DD]  = is_div & (src2 != '0);
    base_f       = pop_ok ? stack_top : alu_valid ? alu_f : flags;
    next_f       = base_f;
    next_f[F_DZ] = (base_f[F_DZ] & ~clr_err) | div0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flags <= '0;
    else flags <= next_f;
endmodule

// File: tb/tb_flag_status_unit.sv
// tb_flag_status_unit: scoreboard bench for flag_status_unit; stack cases run when FLAG_STACK_EN is defined.
module tb_flag_status_unit;
  localparam int DW = 16;
  localparam int SD = 4;
`ifdef FLAG_STACK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_valid = 0, carry_out = 0, overflow_out = 0, push = 0, pop = 0, clr_err = 0;
  logic [DW-1:0] result = '0, src2 = '0;
  logic [3:0] opcode = '0;
  logic [5:0] flags;
  logic stack_full, stack_empty, stack_err;
  int checks = 0, errors = 0;
  logic [5:0] mf;
  logic [5:0] ms[$];
  logic merr;
  logic [8:0] exp_q[$];

  flag_status_unit #(.DATA_W(DW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .result(result), .carry_out(carry_out),
    .overflow_out(overflow_out), .opcode(opcode), .src2(src2), .push(push), .pop(pop),
    .clr_err(clr_err), .flags(flags), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mf = '0;
    ms.delete();
    merr = 1'b0;
  endtask

  // drive one cycle, push the expected post-edge state, then compare it after the edge
  task automatic step(input string tag, input logic v, input logic [DW-1:0] r, input logic co,
                      input logic ov, input logic [3:0] op, input logic [DW-1:0] s2,
                      input logic pu, input logic po, input logic ce);
    logic [5:0] nf;
    logic pop_ok, push_ok, eset, d0;
    alu_valid = v; result = r; carry_out = co; overflow_out = ov; opcode = op; src2 = s2;
    push = pu; pop = po; clr_err = ce;
    pop_ok  = EN && po && !pu && ms.size() > 0;
    push_ok = EN && pu && !po && ms.size() < SD;
    eset    = EN && ((pu && !po && ms.size() == SD) || (po && !pu && ms.size() == 0));
    d0      = v && op == 4'd3 && s2 == 0;
    nf = mf;
    if (pop_ok) nf = ms.pop_back();
    else if (v) begin
      nf[0] = r == 0;
      nf[2] = r[DW-1];
      if (op == 4'd0 || op == 4'd1) begin nf[1] = co; nf[3] = ov; end
      else if (op == 4'd2 || op == 4'd3) begin nf[1] = 0; nf[3] = 0; end
      nf[4] = op == 4'd3 && s2 != 0;
    end
    nf[5] = (nf[5] && !ce) || d0;
    if (push_ok) ms.push_back(mf);
    mf = nf;
    merr = (merr && !ce) || eset;
    exp_q.push_back({mf, EN && ms.size() == SD, !EN || ms.size() == 0, merr});
    @(posedge clk);
    #1;
    check(tag, {7'd0, flags, stack_full, stack_empty, stack_err}, {7'd0, exp_q.pop_front()});
    alu_valid = 0; push = 0; pop = 0; clr_err = 0;
  endtask

  initial begin
    model_reset();
    #3;
    check("reset", {7'd0, flags, stack_full, stack_empty, stack_err}, {7'd0, 6'b0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("add_zero_carry", 1, 16'h0000, 1, 0, 4'd0, 16'h0001, 0, 0, 0);
    check("add_flags_const", {10'd0, flags}, 16'h0003);
    step("div_by_zero", 1, 16'h0005, 0, 0, 4'd3, 16'h0000, 0, 0, 0);
    check("dz_set_const", {10'd0, flags}, 16'h0020);
    step("dz_sticky", 1, 16'h0001, 0, 0, 4'd0, 16'h0002, 0, 0, 0);
    step("clr_err", 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 0, 1);
    check("dz_clear_const", {10'd0, flags}, 16'h0000);
    step("div_ok", 1, 16'h8000, 1, 1, 4'd3, 16'h0003, 0, 0, 0);
    check("div_ok_const", {10'd0, flags}, 16'h0014);
    step("mul_zero", 1, 16'h0000, 1, 1, 4'd2, 16'h0000, 0, 0, 0);
    step("add_cv", 1, 16'h0007, 1, 1, 4'd0, 16'h0000, 0, 0, 0);
    step("op4_hold_cv", 1, 16'h0000, 0, 0, 4'd4, 16'h0000, 0, 0, 0);
    step("idle_hold", 0, 16'h1234, 0, 1, 4'd1, 16'h0000, 0, 0, 0);
    step("dz_set_wins_clr", 1, 16'h0001, 0, 0, 4'd3, 16'h0000, 0, 0, 1);
    step("clr_again", 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 0, 1);
    step("add_prep", 1, 16'h0000, 1, 0, 4'd0, 16'h0000, 0, 0, 0);
    step("push_sub", 1, 16'h0001, 0, 0, 4'd1, 16'h0000, 1, 0, 0);
    check("push_sub_const", {10'd0, flags}, 16'h0000);
    step("pop_restore", 1, 16'h8000, 1, 1, 4'd0, 16'h0000, 0, 1, 0);
    if (EN) check("pop_restore_const", {10'd0, flags}, 16'h0003);
    step("push_pop_both", 1, 16'hFFFF, 0, 1, 4'd1, 16'h0000, 1, 1, 0);
    step("push_for_div0", 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 1, 0, 0);
    step("pop_div0_or", 1, 16'h0000, 0, 0, 4'd3, 16'h0000, 0, 1, 0);
    step("clr_dz", 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step("push_fill", 1, DW'(i), 1, 0, 4'd0, 16'h0000, 1, 0, 0);
      if (EN && i == 3) check("full_after_4", {15'd0, stack_full}, 16'd1);
      if (EN && i == 4) check("err_after_5", {15'd0, stack_err}, 16'd1);
    end
    for (int i = 0; i < 5; i++) step("pop_drain", 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 1, 0);
    check("empty_after_pops", {15'd0, stack_empty}, 16'd1);
    if (EN) check("err_stays", {15'd0, stack_err}, 16'd1);
    step("clr_vs_err_set", 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 1, 1);
    step("clr_stack_err", 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 0, 1);
    for (int i = 0; i < 300; i++)
      step("random", 1'($urandom), DW'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom),
           1'($urandom), 4'($urandom), DW'($urandom_range(0, 2) == 0 ? 0 : $urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
    step("clr_pre_reset", 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 0, 1);
    while (ms.size() > 0) step("drain", 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 1, 0);
    step("push_a", 1, 16'h0000, 1, 1, 4'd0, 16'h0000, 1, 0, 0);
    step("push_b", 1, 16'h0000, 1, 0, 4'd0, 16'h0000, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_flags", {10'd0, flags}, 16'h0000);
    check("async_rst_status", {13'd0, stack_full, stack_empty, stack_err}, 16'b010);
    #2;
    rst_n = 1'b1;
    step("pop_after_reset", 0, 16'h0000, 0, 0, 4'd0, 16'h0000, 0, 1, 0);
    if (EN) check("pop_after_reset_err", {15'd0, stack_err}, 16'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
